// File: rtl/lbist_go_nogo_ctrl.sv
// Logic-BIST go/no-go controller: LFSR-driven scan load, capture pulses, MISR
// compaction of scan-out and a final compare against a golden signature.
module lbist_go_nogo_ctrl #(
   parameter int          SCAN_CHAINS = 2,
   parameter int          CHAIN_LEN   = 4,
   parameter int          N_PATTERNS  = 2,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001,
   parameter logic [31:0] GOLDEN_SIG  = 32'h0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   output logic                   scan_en_o,
   output logic                   test_mode_o,
   output logic [SCAN_CHAINS-1:0] scan_in_o,
   input  logic [SCAN_CHAINS-1:0] scan_out_i,
   output logic                   done_o,
   output logic                   go_nogo_o,
   output logic [31:0]            signature_o
);

   typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, COMPARE, DONE} state_t;

   localparam int          SC_W      = $clog2(CHAIN_LEN);
   localparam int          PC_W      = $clog2(N_PATTERNS + 1);
   localparam logic [31:0] MISR_POLY = 32'h0040_0007;

   state_t            state;
   logic [31:0]       lfsr;
   logic [31:0]       misr;
   logic [SC_W-1:0]   shift_cnt;
   logic [PC_W-1:0]   pat_cnt;

   // Fibonacci form of x^32 + x^22 + x^2 + x + 1
   function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
      return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
   endfunction

   function automatic logic [31:0] misr_next(input logic [31:0] cur,
                                             input logic [SCAN_CHAINS-1:0] so);
      return {cur[30:0], 1'b0} ^ (cur[31] ? MISR_POLY : 32'h0) ^ 32'(so);
   endfunction

   assign scan_in_o   = lfsr[SCAN_CHAINS-1:0];
   assign signature_o = misr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         scan_en_o   <= 1'b0;
         test_mode_o <= 1'b0;
         done_o      <= 1'b0;
         go_nogo_o   <= 1'b0;
         misr        <= 32'h0;
         lfsr        <= LFSR_SEED;
         shift_cnt   <= '0;
         pat_cnt     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state       <= INIT;
                  test_mode_o <= 1'b1;
                  done_o      <= 1'b0;
                  go_nogo_o   <= 1'b0;
               end
            end
            INIT: begin
               lfsr      <= LFSR_SEED;
               misr      <= 32'h0;
               shift_cnt <= '0;
               pat_cnt   <= '0;
               scan_en_o <= 1'b1;
               state     <= SHIFT;
            end
            SHIFT: begin
               lfsr <= lfsr_next(lfsr);
               // the first load window shifts out unknown chain contents
               if (pat_cnt != '0)
                  misr <= misr_next(misr, scan_out_i);
               if (shift_cnt == SC_W'(CHAIN_LEN - 1)) begin
                  shift_cnt <= '0;
                  if (pat_cnt < PC_W'(N_PATTERNS)) begin
                     scan_en_o <= 1'b0;
                     state     <= CAPTURE;
                  end else begin
                     scan_en_o <= 1'b0;
                     state     <= COMPARE;
                  end
               end else begin
                  shift_cnt <= shift_cnt + SC_W'(1);
               end
            end
            CAPTURE: begin
               pat_cnt   <= pat_cnt + PC_W'(1);
               shift_cnt <= '0;
               scan_en_o <= 1'b1;
               state     <= SHIFT;
            end
            COMPARE: begin
               go_nogo_o   <= (misr == GOLDEN_SIG);
               done_o      <= 1'b1;
               test_mode_o <= 1'b0;
               state       <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
